cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates the L1 instruction-cache and L1 data-cache miss/writeback ports onto the single shared downstream memory port (L2 or physical memory). It sits directly downstream of both `cache_control` instances and consumes their `downstream_read`/`downstream_write` requests. It holds one grant for the full duration of a line transaction and returns `resp` only to the granted cache. Arbitration is round-robin, so neither cache starves.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `LINE_WIDTH`, 256, cache line width in bits
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `icache_read`  in  1  I-cache line fill request
- `icache_address`  in  ADDR_WIDTH  I-cache line address
- `icache_rdata`  out  LINE_WIDTH  fill data to I-cache
- `icache_resp`  out  1  I-cache transaction complete
- `dcache_read`  in  1  D-cache line fill request
- `dcache_write`  in  1  D-cache writeback request
- `dcache_address`  in  ADDR_WIDTH  D-cache line address
- `dcache_wdata`  in  LINE_WIDTH  writeback data
- `dcache_rdata`  out  LINE_WIDTH  fill data to D-cache
- `dcache_resp`  out  1  D-cache transaction complete
- `mem_read`  out  1  downstream read strobe
- `mem_write`  out  1  downstream write strobe
- `mem_address`  out  ADDR_WIDTH  downstream address
- `mem_wdata`  out  LINE_WIDTH  downstream write data
- `mem_rdata`  in  LINE_WIDTH  downstream read data
- `mem_resp`  in  1  downstream transaction complete

## Operation
- The FSM has three states: `IDLE`, `SERVE_I`, `SERVE_D`. Register `last_grant` (I/D) tracks the last winner.
- `IDLE`:
  - Only I requests: go to `SERVE_I`.
  - Only D requests (read or write): go to `SERVE_D`.
  - Both request: grant the side opposite `last_grant`.
  - Neither requests: stay in `IDLE`.
  - Update `last_grant` on entry to a SERVE state.
- `SERVE_I`:
  - `mem_read`=1, `mem_write`=0, `mem_address`=`icache_address`.
  - On `mem_resp`: `icache_resp`=1 in the same cycle, then return to `IDLE`.
- `SERVE_D`:
  - `mem_read`=`dcache_read & ~dcache_write`, `mem_write`=`dcache_write`, `mem_address`=`dcache_address`.
  - On `mem_resp`: `dcache_resp`=1 in the same cycle, then return to `IDLE`.
  - `dcache_read`&`dcache_write` together is illegal upstream. If it occurs, the write takes precedence.
- `mem_wdata`=`dcache_wdata` at all times. `icache_rdata`=`dcache_rdata`=`mem_rdata` at all times, as a pass-through.
- The grant never changes mid-transaction. A competing request waits, whatever its priority.
- The requester must hold address, data and strobe stable until its `resp`, and must deassert in the cycle after `resp`. The cache FSM already does this through its PACTION/IDLE transition.
- `mem_resp` while in `IDLE` is ignored: no upstream `resp`, no state change.
- If a requester drops its strobe while granted (protocol error), the arbiter stays granted until `mem_resp`. Memory strobes follow the requester's strobes.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - Next cycle: state=`IDLE`, `last_grant`=I, so D wins the first tie.
  - `mem_read`, `mem_write`, `icache_resp`, `dcache_resp` = 0.
  - Data outputs remain pass-through.
  - Reset mid-transaction abandons the transaction. No `resp` is issued, and memory strobes drop the following cycle.
- Request seen in `IDLE` at cycle t produces a memory strobe at t+1. Arbitration costs one cycle.
- `mem_resp` at cycle t gives upstream `resp` at t, combinationally. State is `IDLE` at t+1 and memory strobes are 0 at t+1.
- The earliest new grant is evaluated in the `IDLE` cycle at t+1, with its strobe at t+2. There is no bubble beyond this.
- A D-cache writeback followed by a read (dirty eviction) is two independent D transactions. A pending I request may win between them under round-robin; this is acceptable.
- All upstream `resp` and memory strobe outputs are functions of registered state plus current inputs. There is no combinational path from `mem_resp` to `mem_read`/`mem_write`.

## Structure
- The `arb_state_t` enum, `LINE_WIDTH`, and the `grant_t` (I/D) enum belong in `rv32i_types`, shared with `cache_control` and the L2.
- Single flat module. No sub-module is warranted; the round-robin is one flop.

## Test plan
- Reset then idle: after `rst_n` low for 2 cycles, then high, all strobes and `resp` outputs are 0. `mem_resp`=1 pulsed in `IDLE` gives no `resp`.
- Lone I fill:
  - Stimulus: `icache_read`=1 at addr 0x0000_1040; memory answers `mem_resp` on the 5th strobe cycle with rdata=0xA5…A5.
  - Required: `mem_read`=1 from t+1; `icache_resp`=1 exactly with `mem_resp`; `icache_rdata`=0xA5…A5; `dcache_resp` never asserted.
- Simultaneous I read (0x100) and D read (0x200) after reset:
  - D is served first (`mem_address`=0x200), then I (0x100).
  - The next tie goes to D again.
- Dirty eviction:
  - D write to 0x300 with wdata=0xDEAD…, then D read of 0x400, while I holds a request at 0x500.
  - Required order: write 0x300, I 0x500, read 0x400.
  - `mem_wdata` matches during the write.
- Reset mid-`SERVE_D`, 2 cycles into a write: `mem_write`=0 the next cycle, no `dcache_resp`, and a tie afterwards goes to D.
- Back-to-back: D issues a new request the cycle after `resp`. The second `mem_read` rises exactly 2 cycles after the first `mem_resp`.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared memory-hierarchy types: line width, arbiter state encoding and
// the I/D grant identifier used by cache_control, the L2 and cache_arbiter.
package rv32i_types;

  localparam int LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Round-robin pick for a cycle with at least one request: a lone requester
  // wins outright, a tie goes to the side that did not win last time.
  function automatic grant_t rr_pick(input grant_t last, input logic i_req, input logic d_req);
    if (i_req && d_req) return (last == GRANT_I) ? GRANT_D : GRANT_I;
    return i_req ? GRANT_I : GRANT_D;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter placing the L1 I-cache and D-cache line transactions
// onto one shared downstream memory port; a grant is held until mem_resp.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = rv32i_types::LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t state, state_nxt;
  grant_t     last_grant, last_grant_nxt;
  logic       i_req, d_req;
  logic       serve_i, serve_d;
  grant_t     pick;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;
  assign pick  = rr_pick(last_grant, i_req, d_req);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_nxt      = (pick == GRANT_I) ? SERVE_I : SERVE_D;
          last_grant_nxt = pick;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign serve_i = (state == SERVE_I);
  assign serve_d = (state == SERVE_D);

  // Strobes track the granted requester's own strobes; a write outranks an
  // illegal simultaneous read from the D-cache.
  assign mem_read    = (serve_i & icache_read) | (serve_d & dcache_read & ~dcache_write);
  assign mem_write   = serve_d & dcache_write;
  assign mem_address = serve_d ? dcache_address : icache_address;
  assign mem_wdata   = dcache_wdata;

  assign icache_resp  = serve_i & mem_resp;
  assign dcache_resp  = serve_d & mem_resp;
  assign icache_rdata = mem_rdata;
  assign dcache_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: queue-driven cache requesters, a fixed
// latency memory responder, a transaction-level grant model and literal checks.
module tb_cache_arbiter;

  localparam int AW  = 32;
  localparam int LW  = 256;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          icache_read = 1'b0;
  logic [AW-1:0] icache_address = '0;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read = 1'b0;
  logic          dcache_write = 1'b0;
  logic [AW-1:0] dcache_address = '0;
  logic [LW-1:0] dcache_wdata = '0;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Stimulus-owned controls
  logic          resp_en = 1'b0;
  logic          manual_resp = 1'b0;
  logic          flush = 1'b0;
  logic [LW-1:0] rdata_pat = '0;
  logic [AW-1:0] iq_addr [32];
  logic          dq_wr   [32];
  logic [AW-1:0] dq_addr [32];
  logic [LW-1:0] dq_data [32];
  int            i_wr = 0, d_wr = 0;
  string         lit_name [64];
  logic [LW-1:0] lit_act  [64];
  logic [LW-1:0] lit_exp  [64];
  int            lit_wr = 0;

  // Driver-owned
  int i_rd = 0, d_rd = 0, i_seen = 0, d_seen = 0;

  // Monitor-owned
  int            checks = 0, errors = 0, lit_rd = 0, cyc = 0;
  int            i_resp_total = 0, d_resp_total = 0;
  int            ireq_cyc = 0, rd_rise_cyc = 0, i_resp_cyc = 0;
  logic [AW-1:0] start_log [32];
  int            n_start = 0;
  logic [LW-1:0] last_i_rdata = '0, last_wdata = '0;
  logic          prev_strobe = 1'b0, prev_read = 1'b0, prev_iread = 1'b0;
  logic          i_own, d_own, exp_mr, exp_mw;

  // Model-owned: 0 = nobody granted, 1 = I-cache, 2 = D-cache
  int   owner = 0;
  logic last_d = 1'b0;
  logic model_valid = 1'b0;

  // Requesters: each side presents the head of its queue and moves on once
  // its resp has been seen, so a follow-on request appears the cycle after resp.
  always @(posedge clk) begin
    #1;
    if (i_resp_total != i_seen) begin i_seen = i_resp_total; i_rd++; end
    if (d_resp_total != d_seen) begin d_seen = d_resp_total; d_rd++; end
    if (flush) begin i_rd = i_wr; d_rd = d_wr; end
    if (i_rd < i_wr) begin
      icache_read = 1'b1; icache_address = iq_addr[i_rd];
    end else icache_read = 1'b0;
    if (d_rd < d_wr) begin
      dcache_write = dq_wr[d_rd]; dcache_read = ~dq_wr[d_rd];
      dcache_address = dq_addr[d_rd]; dcache_wdata = dq_data[d_rd];
    end else begin
      dcache_write = 1'b0; dcache_read = 1'b0;
    end
  end

  // Memory: answers on the LAT-th consecutive strobe cycle
  int scnt = 0;
  always @(posedge clk) begin
    #2;
    mem_rdata = rdata_pat;
    if (resp_en) begin
      if (mem_read || mem_write) begin scnt++; mem_resp = (scnt == LAT); end
      else begin scnt = 0; mem_resp = 1'b0; end
    end else begin
      scnt = 0; mem_resp = manual_resp;
    end
  end

  // Grant model: who owns the memory port, from the arbitration rules
  always @(posedge clk) begin
    if (!rst_n) begin
      owner = 0; last_d = 1'b0; model_valid = 1'b1;
    end else if (owner == 0) begin
      if (icache_read && (dcache_read || dcache_write)) owner = last_d ? 1 : 2;
      else if (icache_read) owner = 1;
      else if (dcache_read || dcache_write) owner = 2;
      if (owner != 0) last_d = (owner == 2);
    end else if (mem_resp) owner = 0;
  end

  task automatic chk(input string n, input logic [LW-1:0] a, input logic [LW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (model_valid) begin
      i_own  = (owner == 1);
      d_own  = (owner == 2);
      exp_mr = (i_own & icache_read) | (d_own & dcache_read & ~dcache_write);
      exp_mw = d_own & dcache_write;
      chk("mem_read", LW'(mem_read), LW'(exp_mr));
      chk("mem_write", LW'(mem_write), LW'(exp_mw));
      chk("icache_resp", LW'(icache_resp), LW'(i_own & mem_resp));
      chk("dcache_resp", LW'(dcache_resp), LW'(d_own & mem_resp));
      if (exp_mr || exp_mw)
        chk("mem_address", LW'(mem_address), LW'(d_own ? dcache_address : icache_address));
      chk("mem_wdata", mem_wdata, dcache_wdata);
      chk("icache_rdata", icache_rdata, mem_rdata);
      chk("dcache_rdata", dcache_rdata, mem_rdata);
    end
    if ((mem_read || mem_write) && !prev_strobe && n_start < 32) begin
      start_log[n_start] = mem_address; n_start++;
    end
    if (mem_read && !prev_read) rd_rise_cyc = cyc;
    if (icache_read && !prev_iread) ireq_cyc = cyc;
    if (icache_resp) begin i_resp_total++; i_resp_cyc = cyc; last_i_rdata = icache_rdata; end
    if (dcache_resp) d_resp_total++;
    if (mem_write && mem_resp) last_wdata = mem_wdata;
    prev_strobe = mem_read | mem_write;
    prev_read   = mem_read;
    prev_iread  = icache_read;
    while (lit_rd < lit_wr) begin
      chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd++;
    end
  end

  task automatic lit(input string n, input logic [LW-1:0] a, input logic [LW-1:0] e);
    if (lit_wr < 64) begin
      lit_name[lit_wr] = n; lit_act[lit_wr] = a; lit_exp[lit_wr] = e; lit_wr++;
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic push_i(input logic [AW-1:0] a);
    iq_addr[i_wr] = a; i_wr++;
  endtask

  task automatic push_d(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    dq_wr[d_wr] = w; dq_addr[d_wr] = a; dq_data[d_wr] = d; d_wr++;
  endtask

  task automatic wait_idle();
    int k = 0;
    cyc_wait(1);
    while (((i_rd != i_wr) || (d_rd != d_wr) || mem_read || mem_write) && k < 400) begin
      cyc_wait(1); k++;
    end
    if (k >= 400) lit("wait_idle_timeout", LW'(1), LW'(0));
  endtask

  int base, i0, d0, wc, k, t1;

  initial begin
    // Reset held for two edges, then idle with a stray mem_resp
    rdata_pat = {8{32'h3C3C_5A5A}};
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    cyc_wait(2);
    lit("rst_mem_read", LW'(mem_read), LW'(0));
    lit("rst_mem_write", LW'(mem_write), LW'(0));
    lit("rst_icache_resp", LW'(icache_resp), LW'(0));
    lit("rst_dcache_resp", LW'(dcache_resp), LW'(0));
    manual_resp = 1'b1;
    cyc_wait(1);
    lit("idle_pulse_present", LW'(mem_resp), LW'(1));
    lit("idle_pulse_icache_resp", LW'(icache_resp), LW'(0));
    lit("idle_pulse_dcache_resp", LW'(dcache_resp), LW'(0));
    manual_resp = 1'b0;
    cyc_wait(1);
    lit("idle_pulse_no_strobe", LW'(mem_read | mem_write), LW'(0));

    // Lone I-cache fill
    resp_en = 1'b1;
    rdata_pat = {32{8'hA5}};
    base = n_start; i0 = i_resp_total; d0 = d_resp_total;
    push_i(32'h0000_1040);
    wait_idle();
    lit("lone_i_starts", LW'(n_start - base), LW'(1));
    lit("lone_i_addr", LW'(start_log[base]), LW'(32'h0000_1040));
    lit("lone_i_strobe_latency", LW'(rd_rise_cyc - ireq_cyc), LW'(1));
    lit("lone_i_resp_on_5th", LW'(i_resp_cyc - rd_rise_cyc + 1), LW'(5));
    lit("lone_i_rdata", last_i_rdata, {32{8'hA5}});
    lit("lone_i_resp_count", LW'(i_resp_total - i0), LW'(1));
    lit("lone_i_no_dresp", LW'(d_resp_total - d0), LW'(0));

    // Ties: D first after reset, and again on the following tie
    rdata_pat = {8{32'h1234_5678}};
    base = n_start;
    push_i(32'h100); push_d(1'b0, 32'h200, '0);
    wait_idle();
    lit("tie1_first", LW'(start_log[base]), LW'(32'h200));
    lit("tie1_second", LW'(start_log[base + 1]), LW'(32'h100));
    base = n_start;
    push_i(32'h110); push_d(1'b0, 32'h210, '0);
    wait_idle();
    lit("tie2_first", LW'(start_log[base]), LW'(32'h210));
    lit("tie2_second", LW'(start_log[base + 1]), LW'(32'h110));

    // Dirty eviction with an I request waiting
    base = n_start;
    push_d(1'b1, 32'h300, {8{32'hDEAD_BEEF}});
    push_d(1'b0, 32'h400, '0);
    push_i(32'h500);
    wait_idle();
    lit("evict_first", LW'(start_log[base]), LW'(32'h300));
    lit("evict_second", LW'(start_log[base + 1]), LW'(32'h500));
    lit("evict_third", LW'(start_log[base + 2]), LW'(32'h400));
    lit("evict_wdata", last_wdata, {8{32'hDEAD_BEEF}});

    // Reset two cycles into a D write
    base = n_start; d0 = d_resp_total;
    push_d(1'b1, 32'h600, {8{32'hCAFE_F00D}});
    wc = 0; k = 0;
    while (wc < 2 && k < 100) begin
      cyc_wait(1); k++;
      if (mem_write) wc++;
    end
    if (wc < 2) lit("rst_mid_no_write_seen", LW'(wc), LW'(2));
    rst_n = 1'b0; flush = 1'b1;
    cyc_wait(1);
    lit("rst_mid_mem_write", LW'(mem_write), LW'(0));
    lit("rst_mid_mem_read", LW'(mem_read), LW'(0));
    lit("rst_mid_no_dresp", LW'(d_resp_total - d0), LW'(0));
    rst_n = 1'b1; flush = 1'b0;
    cyc_wait(1);
    push_i(32'h700); push_d(1'b0, 32'h800, '0);
    wait_idle();
    lit("rst_mid_aborted", LW'(start_log[base]), LW'(32'h600));
    lit("rst_mid_tie_first", LW'(start_log[base + 1]), LW'(32'h800));
    lit("rst_mid_tie_second", LW'(start_log[base + 2]), LW'(32'h700));
    lit("rst_mid_dresp_count", LW'(d_resp_total - d0), LW'(1));

    // Back-to-back D reads
    base = n_start; d0 = d_resp_total;
    push_d(1'b0, 32'h900, '0); push_d(1'b0, 32'h910, '0);
    k = 0;
    while (d_resp_total == d0 && k < 100) begin cyc_wait(1); k++; end
    t1 = cyc;
    wait_idle();
    lit("b2b_gap", LW'(rd_rise_cyc - t1), LW'(2));
    lit("b2b_first", LW'(start_log[base]), LW'(32'h900));
    lit("b2b_second", LW'(start_log[base + 1]), LW'(32'h910));

    cyc_wait(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
